// File: rtl/fft_18bit.sv
// 8-point radix-2 decimation-in-frequency FFT, fully pipelined: one frame per clock.
// Q8 internal format, 36-bit wrapping arithmetic, results reordered to natural order.
module fft_18bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] r0,
    input  logic [17:0] r1,
    input  logic [17:0] r2,
    input  logic [17:0] r3,
    input  logic [17:0] r4,
    input  logic [17:0] r5,
    input  logic [17:0] r6,
    input  logic [17:0] r7,
    input  logic [17:0] i0,
    input  logic [17:0] i1,
    input  logic [17:0] i2,
    input  logic [17:0] i3,
    input  logic [17:0] i4,
    input  logic [17:0] i5,
    input  logic [17:0] i6,
    input  logic [17:0] i7,
    output logic [35:0] or0,
    output logic [35:0] or1,
    output logic [35:0] or2,
    output logic [35:0] or3,
    output logic [35:0] or4,
    output logic [35:0] or5,
    output logic [35:0] or6,
    output logic [35:0] or7,
    output logic [35:0] oi0,
    output logic [35:0] oi1,
    output logic [35:0] oi2,
    output logic [35:0] oi3,
    output logic [35:0] oi4,
    output logic [35:0] oi5,
    output logic [35:0] oi6,
    output logic [35:0] oi7
);

    logic [17:0]        in_re_s  [8];
    logic [17:0]        in_im_s  [8];
    logic signed [35:0] x_re_r   [8];
    logic signed [35:0] x_im_r   [8];
    logic signed [35:0] d_re_s   [4];
    logic signed [35:0] d_im_s   [4];
    logic signed [35:0] s1_re_s  [8];
    logic signed [35:0] s1_im_s  [8];
    logic signed [35:0] s1_re_r  [8];
    logic signed [35:0] s1_im_r  [8];
    logic signed [35:0] s2_re_s  [8];
    logic signed [35:0] s2_im_s  [8];
    logic signed [35:0] s2_re_r  [8];
    logic signed [35:0] s2_im_r  [8];
    logic signed [35:0] nat_re_s [8];
    logic signed [35:0] nat_im_s [8];
    logic signed [35:0] out_re_r [8];
    logic signed [35:0] out_im_r [8];

    // Multiply by 181/256 (~1/sqrt(2)); product wraps to 36 bits, shift floors.
    function automatic logic signed [35:0] scale_r2(input logic signed [35:0] v);
        logic signed [35:0] p;
        p = v * 36'sd181;
        return p >>> 6'd8;
    endfunction

    // Gather the flat input ports into arrays.
    always_comb begin
        in_re_s[0] = r0; in_re_s[1] = r1; in_re_s[2] = r2; in_re_s[3] = r3;
        in_re_s[4] = r4; in_re_s[5] = r5; in_re_s[6] = r6; in_re_s[7] = r7;
        in_im_s[0] = i0; in_im_s[1] = i1; in_im_s[2] = i2; in_im_s[3] = i3;
        in_im_s[4] = i4; in_im_s[5] = i5; in_im_s[6] = i6; in_im_s[7] = i7;
    end

    // Stage 1: span-4 butterflies, then twiddles W^0..W^3 on the difference half.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            s1_re_s[k] = 36'sd0;
            s1_im_s[k] = 36'sd0;
        end
        for (int n = 0; n < 4; n++) begin
            d_re_s[n]  = x_re_r[n] - x_re_r[n+4];
            d_im_s[n]  = x_im_r[n] - x_im_r[n+4];
            s1_re_s[n] = x_re_r[n] + x_re_r[n+4];
            s1_im_s[n] = x_im_r[n] + x_im_r[n+4];
        end
        s1_re_s[4] = d_re_s[0];
        s1_im_s[4] = d_im_s[0];
        s1_re_s[5] = scale_r2(d_re_s[1] + d_im_s[1]);
        s1_im_s[5] = scale_r2(d_im_s[1] - d_re_s[1]);
        s1_re_s[6] = d_im_s[2];
        s1_im_s[6] = -d_re_s[2];
        s1_re_s[7] = scale_r2(d_im_s[3] - d_re_s[3]);
        s1_im_s[7] = scale_r2(-d_re_s[3] - d_im_s[3]);
    end

    // Stage 2: span-2 butterflies in each half; odd difference rotated by -j.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            s2_re_s[k] = 36'sd0;
            s2_im_s[k] = 36'sd0;
        end
        for (int g = 0; g < 8; g += 4) begin
            s2_re_s[g]   = s1_re_r[g]   + s1_re_r[g+2];
            s2_im_s[g]   = s1_im_r[g]   + s1_im_r[g+2];
            s2_re_s[g+1] = s1_re_r[g+1] + s1_re_r[g+3];
            s2_im_s[g+1] = s1_im_r[g+1] + s1_im_r[g+3];
            s2_re_s[g+2] = s1_re_r[g]   - s1_re_r[g+2];
            s2_im_s[g+2] = s1_im_r[g]   - s1_im_r[g+2];
            s2_re_s[g+3] = s1_im_r[g+1] - s1_im_r[g+3];
            s2_im_s[g+3] = s1_re_r[g+3] - s1_re_r[g+1];
        end
    end

    // Stage 3: span-1 butterflies written straight into natural-order slots.
    always_comb begin
        nat_re_s[0] = s2_re_r[0] + s2_re_r[1];
        nat_im_s[0] = s2_im_r[0] + s2_im_r[1];
        nat_re_s[4] = s2_re_r[0] - s2_re_r[1];
        nat_im_s[4] = s2_im_r[0] - s2_im_r[1];
        nat_re_s[2] = s2_re_r[2] + s2_re_r[3];
        nat_im_s[2] = s2_im_r[2] + s2_im_r[3];
        nat_re_s[6] = s2_re_r[2] - s2_re_r[3];
        nat_im_s[6] = s2_im_r[2] - s2_im_r[3];
        nat_re_s[1] = s2_re_r[4] + s2_re_r[5];
        nat_im_s[1] = s2_im_r[4] + s2_im_r[5];
        nat_re_s[5] = s2_re_r[4] - s2_re_r[5];
        nat_im_s[5] = s2_im_r[4] - s2_im_r[5];
        nat_re_s[3] = s2_re_r[6] + s2_re_r[7];
        nat_im_s[3] = s2_im_r[6] + s2_im_r[7];
        nat_re_s[7] = s2_re_r[6] - s2_re_r[7];
        nat_im_s[7] = s2_im_r[6] - s2_im_r[7];
    end

    // Pipeline registers: Q8 capture, stage 1, stage 2, output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                x_re_r[k]   <= 36'sd0;
                x_im_r[k]   <= 36'sd0;
                s1_re_r[k]  <= 36'sd0;
                s1_im_r[k]  <= 36'sd0;
                s2_re_r[k]  <= 36'sd0;
                s2_im_r[k]  <= 36'sd0;
                out_re_r[k] <= 36'sd0;
                out_im_r[k] <= 36'sd0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                x_re_r[k]   <= {{10{in_re_s[k][17]}}, in_re_s[k], 8'd0};
                x_im_r[k]   <= {{10{in_im_s[k][17]}}, in_im_s[k], 8'd0};
                s1_re_r[k]  <= s1_re_s[k];
                s1_im_r[k]  <= s1_im_s[k];
                s2_re_r[k]  <= s2_re_s[k];
                s2_im_r[k]  <= s2_im_s[k];
                out_re_r[k] <= nat_re_s[k];
                out_im_r[k] <= nat_im_s[k];
            end
        end
    end

    assign or0 = out_re_r[0];
    assign or1 = out_re_r[1];
    assign or2 = out_re_r[2];
    assign or3 = out_re_r[3];
    assign or4 = out_re_r[4];
    assign or5 = out_re_r[5];
    assign or6 = out_re_r[6];
    assign or7 = out_re_r[7];
    assign oi0 = out_im_r[0];
    assign oi1 = out_im_r[1];
    assign oi2 = out_im_r[2];
    assign oi3 = out_im_r[3];
    assign oi4 = out_im_r[4];
    assign oi5 = out_im_r[5];
    assign oi6 = out_im_r[6];
    assign oi7 = out_im_r[7];

endmodule

// File: tb/tb_fft_18bit.sv
// Directed bench for fft_18bit: hand-computed ramp/impulse/DC results, a reference
// DFT model for arbitrary frames, 4-edge latency tracking and async reset checks.
module tb_fft_18bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] in_re [8];
    logic [17:0] in_im [8];
    logic [35:0] o_re  [8];
    logic [35:0] o_im  [8];
    logic [35:0] cur_re [8];
    logic [35:0] cur_im [8];
    logic [35:0] exp_re [4][8];
    logic [35:0] exp_im [4][8];
    int          vectors = 0;
    int          errors  = 0;

    int ramp_xr [8] = '{9216, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
    int ramp_xi [8] = '{0, 2472, 1024, 424, 0, -424, -1024, -2472};
    logic [17:0] cx_re [8] = '{18'h00085, 18'h3FF45, 18'h00085, 18'h3FFF9,
                               18'h3FFD6, 18'h3FFF9, 18'h3FFEC, 18'h3FF7C};
    logic [17:0] cx_im [8] = '{18'h3FF53, 18'h3FEFE, 18'h3FF53, 18'h3FEFF,
                               18'h3FFAE, 18'h3FEFE, 18'h3FFAC, 18'h3FF79};

    always #5 clk = ~clk;

    fft_18bit dut (
        .clk(clk), .rst_n(rst_n),
        .r0(in_re[0]), .r1(in_re[1]), .r2(in_re[2]), .r3(in_re[3]),
        .r4(in_re[4]), .r5(in_re[5]), .r6(in_re[6]), .r7(in_re[7]),
        .i0(in_im[0]), .i1(in_im[1]), .i2(in_im[2]), .i3(in_im[3]),
        .i4(in_im[4]), .i5(in_im[5]), .i6(in_im[6]), .i7(in_im[7]),
        .or0(o_re[0]), .or1(o_re[1]), .or2(o_re[2]), .or3(o_re[3]),
        .or4(o_re[4]), .or5(o_re[5]), .or6(o_re[6]), .or7(o_re[7]),
        .oi0(o_im[0]), .oi1(o_im[1]), .oi2(o_im[2]), .oi3(o_im[3]),
        .oi4(o_im[4]), .oi5(o_im[5]), .oi6(o_im[6]), .oi7(o_im[7])
    );

    // Generic in-place DIF over the current inputs, results stored bit-reversed-corrected.
    task automatic model_fft();
        longint xr [8];
        longint xi [8];
        longint dr, di, tr, ti;
        int     tw, br;
        for (int n = 0; n < 8; n++) begin
            xr[n] = longint'($signed(in_re[n])) * 256;
            xi[n] = longint'($signed(in_im[n])) * 256;
        end
        for (int span = 4; span >= 1; span = span / 2) begin
            for (int base = 0; base < 8; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    dr = xr[base+j] - xr[base+j+span];
                    di = xi[base+j] - xi[base+j+span];
                    xr[base+j] = xr[base+j] + xr[base+j+span];
                    xi[base+j] = xi[base+j] + xi[base+j+span];
                    tw = j * (4 / span);
                    case (tw)
                        1: begin tr = ((dr + di) * 181) >>> 8; ti = ((di - dr) * 181) >>> 8; end
                        2: begin tr = di; ti = -dr; end
                        3: begin tr = ((di - dr) * 181) >>> 8; ti = ((-dr - di) * 181) >>> 8; end
                        default: begin tr = dr; ti = di; end
                    endcase
                    xr[base+j+span] = tr;
                    xi[base+j+span] = ti;
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            br = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            cur_re[br] = xr[i][35:0];
            cur_im[br] = xi[i][35:0];
        end
    endtask

    // kind: 0 ramp, 1 impulse, 2 full-scale negative DC, 3 complex frame, 4 random
    task automatic load(input int kind);
        for (int n = 0; n < 8; n++) begin
            in_re[n]  = 18'd0;
            in_im[n]  = 18'd0;
            cur_re[n] = 36'd0;
            cur_im[n] = 36'd0;
        end
        case (kind)
            0: for (int n = 0; n < 8; n++) begin
                   in_re[n]  = 18'(n + 1);
                   cur_re[n] = 36'(ramp_xr[n]);
                   cur_im[n] = 36'(ramp_xi[n]);
               end
            1: begin
                   in_re[0] = 18'd1;
                   for (int n = 0; n < 8; n++) cur_re[n] = 36'd256;
               end
            2: begin
                   for (int n = 0; n < 8; n++) in_re[n] = 18'h20000;
                   cur_re[0] = 36'hFF0000000;
               end
            3: begin
                   for (int n = 0; n < 8; n++) begin
                       in_re[n] = cx_re[n];
                       in_im[n] = cx_im[n];
                   end
                   model_fft();
               end
            default: begin
                   for (int n = 0; n < 8; n++) begin
                       in_re[n] = 18'($urandom);
                       in_im[n] = 18'($urandom);
                   end
                   model_fft();
               end
        endcase
    endtask

    task automatic check(input string tag);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            assert (o_re[k] === exp_re[3][k]) else begin
                errors++;
                $error("FAIL %s X%0d re: got %h, expected %h", tag, k, o_re[k], exp_re[3][k]);
            end
            vectors++;
            assert (o_im[k] === exp_im[3][k]) else begin
                errors++;
                $error("FAIL %s X%0d im: got %h, expected %h", tag, k, o_im[k], exp_im[3][k]);
            end
        end
    endtask

    task automatic clear_pipe();
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++) begin
                exp_re[p][k] = 36'd0;
                exp_im[p][k] = 36'd0;
            end
    endtask

    // One clock edge: the current frame enters the expected pipe (zero if held in reset).
    task automatic step(input bit live, input string tag);
        @(posedge clk);
        #1;
        for (int p = 3; p > 0; p--)
            for (int k = 0; k < 8; k++) begin
                exp_re[p][k] = exp_re[p-1][k];
                exp_im[p][k] = exp_im[p-1][k];
            end
        for (int k = 0; k < 8; k++) begin
            exp_re[0][k] = live ? cur_re[k] : 36'd0;
            exp_im[0][k] = live ? cur_im[k] : 36'd0;
        end
        check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        load(0);
        #2;
        clear_pipe();
        check("reset_init");
        step(1'b0, "reset_hold");
        #2 rst_n = 1'b1;

        for (int s = 0; s < 6; s++) step(1'b1, "ramp_hold");
        load(1); step(1'b1, "impulse");
        load(2); step(1'b1, "neg_dc");
        load(3); step(1'b1, "complex");
        load(0); step(1'b1, "ramp_after_complex");
        for (int s = 0; s < 6; s++) begin
            load(s % 2); step(1'b1, "alternate");
        end
        for (int s = 0; s < 3; s++) begin
            load(4); step(1'b1, "random");
        end
        load(1);
        for (int s = 0; s < 3; s++) step(1'b1, "drain");

        load(0); step(1'b1, "inflight");
        load(2); step(1'b1, "inflight");
        #2 rst_n = 1'b0;
        #1;
        clear_pipe();
        check("async_reset");
        step(1'b0, "reset_mid");
        step(1'b0, "reset_mid");
        #2 rst_n = 1'b1;
        load(1);
        for (int s = 0; s < 5; s++) step(1'b1, "post_release");
        load(0);
        for (int s = 0; s < 4; s++) step(1'b1, "post_release_ramp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
